muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle controller for the RV32M multiply/divide unit in the execute stage.
- Accepts one M-extension op (funct7 = 0000001, opcode 0110011) from the decode/execute control path.
- Runs an iterative shift-add multiply or restoring divide over XLEN cycles.
- Stalls the pipeline while working, then returns a single-cycle-valid result to the EX result mux.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  M-op present in E stage; held high for as long as the instruction stays in E.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
src_a  input  XLEN  rs1 operand (forwarded value).
src_b  input  XLEN  rs2 operand (forwarded value).
flush  input  1  kill the in-flight op (branch/jump flush of E).
busy  output  1  state != IDLE.
stall  output  1  freeze F/D/E pipeline registers.
done  output  1  result valid, one cycle.
result  output  XLEN  op result; holds its last value when done is low.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0, all working registers=0, busy=0, done=0, result=0. rst has priority over flush and start.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, no special case:
  - Latch funct3.
  - Latch magnitudes |a| and |b|. Operands count as signed for MULH/DIV/REM (both), for MULHSU (a only), and for none in MUL/MULHU/DIVU/REMU.
  - Latch the result-sign flags.
  - Set counter=0 and go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- MUL: one step per cycle.
  - If multiplier LSB=1, add the multiplicand to the upper half of the 2*XLEN accumulator.
  - Shift right 1 and increment the counter.
  - After XLEN steps, go to FIX.
- DIV: restoring step per cycle.
  - Shift {rem,quot} left 1 and trial-subtract the divisor from rem.
  - If no borrow, keep the difference and set quot LSB=1.
  - After XLEN steps, go to FIX.
- FIX (1 cycle):
  - MUL* ops: negate the 2*XLEN product if signs differ. MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
  - DIV: negate quot if dividend and divisor signs differ.
  - REM: give rem the dividend's sign.
  - Register into result, then go to DONE.
- DONE (1 cycle): done=1 and stall=0, so the pipeline advances and captures result. Next state is always IDLE. start is ignored in DONE, because the same instruction is still in E.
- Special cases, detected in IDLE on start: skip iteration, go straight to DONE with result registered.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give src_a.
  - Signed overflow (DIV/REM with src_a=0x80000000 and src_b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- Latency, measuring the start-accept cycle as cycle 0:
  - Normal op: iterations in cycles 1..XLEN, FIX in cycle XLEN+1, done in cycle XLEN+2 (34 for XLEN=32).
  - Special case: done in cycle 1.
- stall = (state==IDLE & start & ~flush) | (state in {MUL,DIV,FIX}).
  - stall is combinational.
  - stall=0 in DONE and when IDLE with start=0.
- start while busy: ignored; operands are not re-sampled.
- flush=1 at an edge in any non-IDLE state:
  - Go to IDLE next cycle; no done, result unchanged.
  - flush with start in IDLE: the op is not accepted.
- Arithmetic:
  - All negation is two's complement modulo width.
  - |0x80000000| = 0x80000000, treated as unsigned.
  - The accumulator is 2*XLEN wide.
  - The remainder register is XLEN+1 wide for the borrow.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD, start at cycle 0 -> stall high cycles 0..33, done=1 at cycle 34, result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has done at cycle 34.
- Special cases:
  - DIVU 5/0 -> done at cycle 1, result 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- flush=1 at cycle 10 of a DIV -> busy=0 from cycle 11, done never asserts, result keeps its prior value. A new start at cycle 12 runs normally.
- Hold start=1 continuously through DONE -> exactly one done pulse, no relaunch. rst=1 mid-MUL -> next cycle busy=0, result=0, stall=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the execute stage.
// Shift-add multiply and restoring divide, one step per clock, with a
// fix-up cycle for sign correction and a one-cycle done pulse.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc_q;      // {product high, multiplier / product low}
    logic [XLEN-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quot_q;     // dividend shifts out as quotient shifts in
    logic              neg_res_q;  // product / quotient needs negation
    logic              neg_rem_q;  // remainder takes the dividend's sign
    logic [XLEN-1:0]   result_q;

    // Operand decode for the op presented on the inputs.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    // Per-step datapath.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;  // one extra bit so the trial subtract shows a borrow
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_res;

    logic last_step;

    // Sign handling and special-case detection on the incoming operands.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (funct3_i[2]) begin
            a_signed = ~funct3_i[0];
            b_signed = ~funct3_i[0];
        end else begin
            a_signed = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
            b_signed = (funct3_i[1:0] == 2'b01);
        end
        a_neg = a_signed & src_a_i[XLEN-1];
        b_neg = b_signed & src_b_i[XLEN-1];
        // Most negative value maps to itself, read back as unsigned.
        a_mag = a_neg ? -src_a_i : src_a_i;
        b_mag = b_neg ? -src_b_i : src_b_i;

        div_zero = funct3_i[2] & (src_b_i == '0);
        div_ovf  = funct3_i[2] & ~funct3_i[0] & (src_a_i == MinNeg) & (&src_b_i);
        special  = div_zero | div_ovf;

        special_res = '0;
        if (div_zero) begin
            special_res = funct3_i[1] ? src_a_i : '1;
        end else if (div_ovf) begin
            special_res = funct3_i[1] ? '0 : MinNeg;
        end
    end

    // One multiply step, one divide step, and the final sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        div_shift = {rem_q, quot_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};

        prod = neg_res_q ? -acc_q : acc_q;

        fix_res = result_q;
        if (!op_q[2]) begin
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fix_res = neg_res_q ? -quot_q : quot_q;
        end else begin
            fix_res = neg_rem_q ? -rem_q : rem_q;
        end

        last_step = (cnt_q == CntW'(XLEN - 1));
    end

    // Sequencer state, working registers and registered result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && !flush_i) begin
                        op_q <= funct3_i;
                        if (special) begin
                            result_q <= special_res;
                            state_q  <= StDone;
                        end else begin
                            cnt_q     <= '0;
                            opb_q     <= b_mag;
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            if (funct3_i[2]) begin
                                rem_q   <= '0;
                                quot_q  <= a_mag;
                                state_q <= StDiv;
                            end else begin
                                acc_q   <= {{XLEN{1'b0}}, a_mag};
                                state_q <= StMul;
                            end
                        end
                    end
                end
                StMul: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= mul_next;
                        cnt_q <= cnt_q + CntW'(1);
                        if (last_step) begin
                            state_q <= StFix;
                        end
                    end
                end
                StDiv: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        if (!div_diff[XLEN]) begin
                            rem_q  <= div_diff[XLEN-1:0];
                            quot_q <= {quot_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q  <= div_shift[XLEN-1:0];
                            quot_q <= {quot_q[XLEN-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + CntW'(1);
                        if (last_step) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        result_q <= fix_res;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // Same instruction is still in E here, so start is ignored.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall is combinational so the accept cycle itself freezes the pipeline.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            StIdle:             stall_o = start_i & ~flush_i;
            StMul, StDiv, StFix: stall_o = 1'b1;
            default:            stall_o = 1'b0;
        endcase
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed ops with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (plain 64-bit arithmetic and a latency count).
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b;
    logic        busy, stall, done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .src_a_i  (src_a),
        .src_b_i  (src_b),
        .flush_i  (flush),
        .busy_o   (busy),
        .stall_o  (stall),
        .done_o   (done),
        .result_o (result)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    // Transaction model: an accepted op is busy for m_lat cycles, with done
    // and the new result on the last of them.
    bit          m_active = 1'b0;
    int          m_k      = 0;
    int          m_lat    = 0;
    logic [31:0] m_pend   = '0;
    logic [31:0] m_result = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb, sub;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sub = longint'(ub);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub;   return p[31:0];  end
            3'd1: begin p = sa * sb;   return p[63:32]; end
            3'd2: begin p = sa * sub;  return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_result <= '0;
        end else if (m_active) begin
            if (m_k == m_lat || flush) begin
                m_active <= 1'b0;
            end else begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_lat) m_result <= m_pend;
            end
        end else if (start && !flush) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_pend   <= ref_res(funct3, src_a, src_b);
            if (is_special(funct3, src_a, src_b)) begin
                m_lat    <= 1;
                m_result <= ref_res(funct3, src_a, src_b);
            end else begin
                m_lat <= 34;
            end
        end
    end

    // Every-cycle comparison, mid-cycle while inputs and outputs are stable.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'h0, busy}, {31'h0, m_active});
            chk("done", {31'h0, done}, {31'h0, (m_active && m_k == m_lat)});
            chk("stall", {31'h0, stall},
                {31'h0, (m_active ? (m_k < m_lat) : (start && !flush))});
            chk("result", result, m_result);
        end
    end

    // Start an op in the current cycle (cycle 0), hold start through done,
    // and pin result and done latency against literals.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        bit got;
        cyc    = 0;
        got    = 1'b0;
        funct3 = f;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                chk({nm, " result"}, result, exp_res);
                chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!got) chk({nm, " done seen"}, 32'(got), 32'd1);
        start = 1'b0;
        // No relaunch and no second pulse after done with start held.
        repeat (2) begin
            @(negedge clk);
            chk({nm, " no relaunch busy"}, {31'h0, busy}, 32'd0);
            chk({nm, " single done"}, {31'h0, done}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        src_a  = '0;
        src_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset busy", {31'h0, busy}, 32'd0);
        chk("reset done", {31'h0, done}, 32'd0);
        chk("reset stall", {31'h0, stall}, 32'd0);
        chk("reset result", result, 32'd0);
        @(posedge clk);
        #1;

        run_op("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("MULH",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("REM",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("DIVU",   3'd5, 32'd100,        32'd7,         32'd14,        34);
        run_op("REMU",   3'd7, 32'd100,        32'd7,         32'd2,         34);

        // Flush a DIV at cycle 10; result keeps the REMU value.
        funct3 = 3'd4;
        src_a  = 32'd1000;
        src_b  = 32'd3;
        start  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("flush busy", {31'h0, busy}, 32'd0);
        chk("flush result held", result, 32'd2);
        @(posedge clk);
        #1;
        run_op("DIV after flush", 3'd4, 32'd1000, 32'd3, 32'd333, 34);

        run_op("DIVU by zero", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("REMU by zero", 3'd7, 32'd5,         32'd0,         32'd5,         1);
        run_op("DIV overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // Reset in the middle of a multiply.
        funct3 = 3'd0;
        src_a  = 32'd5;
        src_b  = 32'd6;
        start  = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid-mul reset busy", {31'h0, busy}, 32'd0);
        chk("mid-mul reset result", result, 32'd0);
        chk("mid-mul reset stall", {31'h0, stall}, 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic, checked each cycle by the model compare.
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            flush  = ($urandom_range(0, 39) == 0);
            start  = ($urandom_range(0, 2) != 0);
            funct3 = 3'($urandom_range(0, 7));
            src_a  = pick_operand();
            src_b  = pick_operand();
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        flush = 1'b0;
        start = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
